div_unit: RTL and testbench

Iterative 32-bit integer divider with its own sequencing FSM, serving the EX stage's `div.w/div.wu/mod.w/mod.wu` requests. EX holds `div_start_i` high and stalls the pipeline until `div_done_o`. EX reads the quotient from `div_result_o[31:0]` and the remainder from `div_result_o[63:32]`. The block sits beside EX and is the only owner of the division datapath.

---
 rtl/div_unit_pkg.sv | 38 +++
 rtl/div_unit_if.sv | 36 +++
 rtl/div_unit_step.sv | 37 +++
 rtl/div_unit.sv | 151 +++++++++++++++
 tb/tb_div_unit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
//   Shared definitions for the iterative 32-bit divider: operand width,
//   iteration count, FSM state encoding, divide-by-zero result constant,
//   the packed remainder/quotient accumulator and a conditional-negate helper.
// -----------------------------------------------------------------------------
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    // Divide-by-zero result: quotient is all ones, and the remainder is the
    // raw dividend, so only the quotient half is a true constant.
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } div_state_t;

    // Partial remainder and quotient shift register advanced together by one
    // restoring step. The stored remainder is always below the divisor, so it
    // fits in DIV_WIDTH bits; the extra bit only exists inside the step.
    typedef struct packed {
        logic [DIV_WIDTH-1:0] rem;
        logic [DIV_WIDTH-1:0] quo;
    } div_acc_t;

    // Two's-complement negate when neg is set. Negating 0x80000000 wraps to
    // itself, which is what lets the signed overflow case work unchanged.
    function automatic logic [DIV_WIDTH-1:0] cond_neg(input logic [DIV_WIDTH-1:0] v,
                                                      input logic                 neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// -----------------------------------------------------------------------------
// div_unit_if
//   Request/response bundle between the EX stage (master) and the divider
//   (slave).
//     div_start_i   request level, held by EX until div_done_o
//     div_signed_i  1 = signed div.w/mod.w, 0 = unsigned
//     div_data1_i   dividend
//     div_data2_i   divisor
//     flush_i       pipeline flush, cancels any division
//     stall_i       downstream stall, holds a finished result
//     div_result_o  {remainder, quotient}, registered
//     div_done_o    result valid, registered
// -----------------------------------------------------------------------------
interface div_unit_if;
    import div_unit_pkg::*;

    logic                   div_start_i;
    logic                   div_signed_i;
    logic [DIV_WIDTH-1:0]   div_data1_i;
    logic [DIV_WIDTH-1:0]   div_data2_i;
    logic                   flush_i;
    logic                   stall_i;
    logic [2*DIV_WIDTH-1:0] div_result_o;
    logic                   div_done_o;

    modport master (
        output div_start_i, div_signed_i, div_data1_i, div_data2_i, flush_i, stall_i,
        input  div_result_o, div_done_o
    );

    modport slave (
        input  div_start_i, div_signed_i, div_data1_i, div_data2_i, flush_i, stall_i,
        output div_result_o, div_done_o
    );

endinterface

// File: rtl/div_unit_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring shift-subtract step on unsigned magnitudes.
//     acc       current {partial remainder, quotient shift}
//     divisor   divisor magnitude
//     acc_next  accumulator after one step
// -----------------------------------------------------------------------------
module div_step
    import div_unit_pkg::*;
(
    input  div_acc_t             acc,
    input  logic [DIV_WIDTH-1:0] divisor,
    output div_acc_t             acc_next
);

    logic [DIV_WIDTH:0] shifted;
    logic [DIV_WIDTH:0] diff;

    // NOTE: every output of a combinational block is assigned on every path
    // (defaults first where branches differ) so no latch is inferred.
    always_comb begin
        // 33-bit partial remainder: old remainder with the next dividend bit.
        shifted = {acc.rem, acc.quo[DIV_WIDTH-1]};
        diff    = shifted - {1'b0, divisor};

        acc_next.rem = shifted[DIV_WIDTH-1:0];
        acc_next.quo = {acc.quo[DIV_WIDTH-2:0], 1'b0};

        // shifted < 2*divisor always holds, so a non-negative difference fits
        // in DIV_WIDTH bits and the top bit of diff is a clean borrow flag.
        if (!diff[DIV_WIDTH]) begin
            acc_next.rem = diff[DIV_WIDTH-1:0];
            acc_next.quo = {acc.quo[DIV_WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//   Iterative 32-bit integer divider for div.w/div.wu/mod.w/mod.wu. Operands
//   are reduced to magnitudes on accept, divided with 32 restoring steps (one
//   per cycle) and sign-corrected while loading the result register.
//     clk   core clock
//     rst   asynchronous, active-low reset
//     bus   div_unit_if slave: start/signed/operands/flush/stall in,
//           {remainder, quotient} result and done out
//   Latency: 33 cycles from the start edge for a normal divide, 1 cycle for a
//   divide-by-zero. A flush cancels in any state without touching the result.
// -----------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    div_state_t           state;
    div_state_t           state_next;

    logic [CNT_W-1:0]     cnt;
    div_acc_t             acc;
    div_acc_t             acc_next;
    logic [DIV_WIDTH-1:0] divisor_q;
    logic                 q_neg;
    logic                 r_neg;
    logic [2*DIV_WIDTH-1:0] result_q;
    logic                 done_q;

    // FSM decode strobes
    logic                 accept;
    logic                 zero_done;
    logic                 finish;

    // Operand decode, only meaningful in the accept cycle
    logic                 d1_neg;
    logic                 d2_neg;
    logic                 div_zero;
    logic [DIV_WIDTH-1:0] q_fix;
    logic [DIV_WIDTH-1:0] r_fix;

    assign d1_neg   = bus.div_signed_i & bus.div_data1_i[DIV_WIDTH-1];
    assign d2_neg   = bus.div_signed_i & bus.div_data2_i[DIV_WIDTH-1];
    assign div_zero = (bus.div_data2_i == '0);

    div_step u_step (
        .acc      (acc),
        .divisor  (divisor_q),
        .acc_next (acc_next)
    );

    // Sign fix-ups applied to the output of the final step.
    assign q_fix = cond_neg(acc_next.quo, q_neg);
    assign r_fix = cond_neg(acc_next.rem, r_neg);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control decode. Flush overrides everything but reset.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        zero_done  = 1'b0;
        finish     = 1'b0;

        if (bus.flush_i) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.div_start_i) begin
                        accept     = 1'b1;
                        zero_done  = div_zero;
                        state_next = div_zero ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_W'(DIV_ITERS - 1)) begin
                        finish     = 1'b1;
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A start seen here is ignored; EX must re-present it in IDLE.
                    if (!bus.stall_i) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: operand latch, iteration, result and done registers
    // -------------------------------------------------------------------------
    // NOTE: the whole datapath is reset, not only the control state, because
    // the result must read zero the moment reset asserts, even mid-divide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            acc       <= '0;
            divisor_q <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            if (accept) begin
                acc.rem   <= '0;
                acc.quo   <= cond_neg(bus.div_data1_i, d1_neg);
                divisor_q <= cond_neg(bus.div_data2_i, d2_neg);
                q_neg     <= d1_neg ^ d2_neg;
                r_neg     <= d1_neg;
                cnt       <= '0;
            end else if (state == ST_RUN) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
            end

            // The result register changes only when a complete answer exists,
            // so a flush never exposes partial state.
            if (zero_done) begin
                result_q <= {bus.div_data1_i, DIV0_QUOTIENT};
            end else if (finish) begin
                result_q <= {r_fix, q_fix};
            end

            done_q <= (state_next == ST_DONE);
        end
    end

    assign bus.div_result_o = result_q;
    assign bus.div_done_o   = done_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
//   Scoreboarded bench for div_unit: each issued request pushes its expected
//   {remainder, quotient} (computed with plain 64-bit arithmetic) into a
//   queue; a monitor pops and compares on every rising div_done_o and checks
//   the result stays stable while done is held. Stimulus checks latency and
//   done duration.
// -----------------------------------------------------------------------------
module tb_div_unit;
    import div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic        mon_prev;
    logic [63:0] mon_cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%016h required 0x%016h", name, act, req);
        end
    endtask

    // Reference: plain integer division on 64-bit values. Truncation toward
    // zero gives C-style signed quotient and dividend-signed remainder.
    function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Monitor: compare on each rising done, then check the result holds.
    initial begin
        mon_prev = 1'b0;
        mon_cur  = '0;
        forever begin
            @(negedge clk);
            if (rst && bus.div_done_o) begin
                if (!mon_prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: result 0x%016h with no request outstanding",
                                 bus.div_result_o);
                    end else begin
                        mon_cur = exp_q.pop_front();
                        check("result", bus.div_result_o, mon_cur);
                    end
                end else begin
                    check("held_result", bus.div_result_o, mon_cur);
                end
                mon_prev = 1'b1;
            end else begin
                mon_prev = 1'b0;
            end
        end
    end

    // Issue one divide and hold start until done; stall the result stall_n cycles.
    task automatic do_div(input bit sg, input logic [31:0] a, input logic [31:0] b, input int stall_n);
        int lat;
        int len;
        bit seen;
        exp_q.push_back(ref_div(sg, a, b));
        bus.div_start_i  = 1'b1;
        bus.div_signed_i = sg;
        bus.div_data1_i  = a;
        bus.div_data2_i  = b;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            seen = bus.div_done_o;
            if (lat == 1) begin
                // Operands must be ignored once the request is accepted.
                bus.div_signed_i = 1'($urandom_range(0, 1));
                bus.div_data1_i  = $urandom();
                bus.div_data2_i  = $urandom();
            end
        end
        bus.div_start_i = 1'b0;
        check("latency", 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
        if (!seen) begin
            exp_q.delete();
            return;
        end
        len         = 1;
        bus.stall_i = (stall_n > 0);
        for (int s = 0; s < stall_n + 2; s++) begin
            @(posedge clk);
            #1;
            if (!bus.div_done_o) break;
            len++;
            if (s + 1 >= stall_n) bus.stall_i = 1'b0;
        end
        bus.stall_i = 1'b0;
        check("done_len", 64'(len), 64'(stall_n + 1));
    endtask

    // Count done cycles over a window where none may appear.
    task automatic expect_quiet(input string name, input int cycles);
        int hits;
        hits = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (bus.div_done_o) hits++;
        end
        check(name, 64'(hits), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bit          sg;

        bus.div_start_i  = 1'b0;
        bus.div_signed_i = 1'b0;
        bus.div_data1_i  = '0;
        bus.div_data2_i  = '0;
        bus.flush_i      = 1'b0;
        bus.stall_i      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 64'(bus.div_done_o), 64'd0);
        check("reset_result", bus.div_result_o, 64'd0);
        rst = 1'b1;
        expect_quiet("idle_after_reset", 2);

        // Directed cases
        do_div(1'b0, 32'd100, 32'd7, 0);
        do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_div(1'b0, 32'd5, 32'd0, 0);
        do_div(1'b1, 32'hFFFF_FFFB, 32'd0, 1);
        do_div(1'b0, 32'd1234567, 32'd89, 3);

        // Flush in RUN cycle 10, then a fresh full-length request
        bus.div_start_i  = 1'b1;
        bus.div_signed_i = 1'b0;
        bus.div_data1_i  = 32'd1000;
        bus.div_data2_i  = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        bus.flush_i     = 1'b1;
        bus.div_start_i = 1'b0;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        check("flush_done", 64'(bus.div_done_o), 64'd0);
        expect_quiet("no_done_after_flush", 40);
        do_div(1'b0, 32'd40, 32'd8, 0);

        // Reset asserted mid-RUN
        bus.div_start_i  = 1'b1;
        bus.div_signed_i = 1'b0;
        bus.div_data1_i  = 32'hDEAD_BEEF;
        bus.div_data2_i  = 32'h0000_1234;
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrun_reset_done", 64'(bus.div_done_o), 64'd0);
        check("midrun_reset_result", bus.div_result_o, 64'd0);
        bus.div_start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_quiet("no_done_after_reset", 40);

        // Randomized requests with occasional zero/small divisors and stalls
        for (int i = 0; i < 24; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom();
            if ($urandom_range(0, 7) == 0)      b = 32'd0;
            else if ($urandom_range(0, 1) == 1) b = 32'($urandom_range(1, 20));
            else                                b = $urandom();
            if ($urandom_range(0, 3) == 0) b = -b;
            do_div(sg, a, b, int'($urandom_range(0, 2)));
        end

        repeat (2) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
